autosa_cacc_regfile_consumer: RTL and testbench
===============================================

Name: autosa_cacc_regfile_consumer

Overview:
- Hardware (consumer) side of the CACC ping-pong register-group protocol.
- Software writes configuration into two register groups.
- `producer` selects the group that software is writing.
- This block arms and launches the two groups in turn and retires them when the datapath reports completion.
- It owns the `consumer` pointer, the per-group op_en bits and the `status_0`/`status_1` fields that the single-register block reads back.

Parameters:
- TIMEOUT_CYCLES, 65535, watchdog limit in clock cycles (used only with the optional feature).
- TMO_CNT_W, 16, width of the watchdog counter; must satisfy 2^TMO_CNT_W > TIMEOUT_CYCLES.

Ports:
- autosa_core_clk  input  1  core clock
- autosa_core_rst  input  1  synchronous active-high reset
- producer  input  1  group currently targeted by software writes
- op_en_wr_en  input  1  single-cycle write strobe to the op_en field of group[producer]
- op_en_wr_data  input  1  value written to op_en
- dp_done  input  1  single-cycle pulse from datapath: current job finished
- consumer  output  1  group currently owned or next to be run by hardware
- status_0  output  2  group 0 status
- status_1  output  2  group 1 status
- op_en_0  output  1  group 0 armed
- op_en_1  output  1  group 1 armed
- cfg_sel  output  1  config mux select to datapath; equals consumer
- dp_start  output  1  single-cycle launch pulse to datapath
- dp_busy  output  1  high while a job is outstanding
- intr_done  output  2  one-cycle completion pulse, bit g for group g

Behaviour:
- One clock, autosa_core_clk. Reset autosa_core_rst is synchronous and active-high.
- Reset values: consumer=0, op_en_0=0, op_en_1=0, dp_start=0, dp_busy=0, intr_done=0, FSM=IDLE, watchdog counter=0.
- Status encoding: 2'd0 IDLE, 2'd1 RUNNING, 2'd2 PENDING; 2'd3 is never produced.
- status_g is combinational from registers:
  - op_en_g=0 → IDLE.
  - op_en_g=1 and consumer==g → RUNNING.
  - otherwise → PENDING.
- op_en write: when op_en_wr_en=1, op_en[producer] takes op_en_wr_data at the next edge.
  - A write of 0 to the group being executed (FSM BUSY or RETIRE and producer==consumer) is ignored; there is no abort.
  - A write of 1 to an already-set bit has no effect.
- FSM states: IDLE, BUSY, RETIRE.
  - IDLE: if op_en[consumer]=1, go to BUSY; dp_start=1 and dp_busy=1 are registered, so both are visible in the first BUSY cycle. dp_start drops after one cycle.
  - BUSY: dp_busy=1. dp_done is sampled only in BUSY cycles after the dp_start cycle. dp_done coincident with dp_start is ignored. On an accepted dp_done, go to RETIRE.
  - RETIRE, one cycle: intr_done[consumer]=1 and dp_busy=0. At the end of the cycle, op_en[consumer] is cleared, consumer is toggled, and the FSM returns to IDLE.
  - dp_done in IDLE or RETIRE is dropped.
- Latency: op_en write strobe in cycle k → op_en=1 in k+1 → dp_start in k+2 (if that group equals consumer and FSM is IDLE).
- dp_done in cycle m → intr_done in m+1 → consumer toggled and op_en cleared in m+2 → dp_start for the other group in m+3 if it is armed.
- Simultaneous events:
  - A software write of 1 to op_en[consumer] in the RETIRE cycle wins over the hardware clear. The bit stays 1, so that group is re-armed and runs again after the other group.
  - A write to the non-consumer group in any state takes effect normally.
- Reset mid-job: every register returns to its reset value on the next edge. No intr_done is emitted.
- Groups are always served in strict alternation. If op_en[consumer]=0, the block waits in IDLE even when the other group is armed. Software must arm groups in producer order.

Optional Feature:
- Macro: AUTOSA_CACC_CONSUMER_TIMEOUT_EN.
- With the macro defined:
  - Adds output `dp_timeout` (1 bit, reset 0).
  - A TMO_CNT_W counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES while still in BUSY, dp_timeout pulses for one cycle and the FSM goes to RETIRE as if dp_done had arrived; intr_done still fires.
  - dp_done in the same cycle as the timeout is treated as a normal done, and dp_timeout stays 0.
- Without the macro: no counter and no dp_timeout port; BUSY waits indefinitely.

Test Plan:
- Reset, then producer=0, write op_en=1 in cycle 5 → op_en_0=1 in cycle 6 and status_0=1; dp_start in cycle 7; dp_done in cycle 20 → intr_done=2'b01 in 21, consumer=1 in 22, status_0=0.
- Arm group 0 and group 1 back-to-back, dp_done for group 0 in cycle m → dp_start for group 1 in m+3; while group 0 runs, status_0=1 and status_1=2.
- Write op_en=0 to the running group during BUSY → ignored: op_en stays 1 and dp_busy stays 1 until dp_done.
- dp_done coincident with dp_start, and dp_done in IDLE → both ignored; FSM stays BUSY (respectively IDLE) and intr_done stays 0.
- Software write op_en=1 to the consumer group in the RETIRE cycle → bit stays 1; that group relaunches after the other group completes.
- With macro, TIMEOUT_CYCLES=10, no dp_done → dp_timeout in the 10th BUSY cycle, then intr_done; assert reset mid-BUSY → all outputs 0 next cycle.

Source files
------------

// File: rtl/autosa_cacc_regfile_consumer.sv
// rtl/autosa_cacc_regfile_consumer.sv - CACC ping-pong register-group consumer FSM
// Optional BUSY watchdog and dp_timeout output enabled by AUTOSA_CACC_CONSUMER_TIMEOUT_EN.
module autosa_cacc_regfile_consumer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_CNT_W      = 16
) (
  input  logic       autosa_core_clk,
  input  logic       autosa_core_rst,
  input  logic       producer,
  input  logic       op_en_wr_en,
  input  logic       op_en_wr_data,
  input  logic       dp_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic       op_en_0,
  output logic       op_en_1,
  output logic       cfg_sel,
  output logic       dp_start,
  output logic       dp_busy,
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
  output logic       dp_timeout,
`endif
  output logic [1:0] intr_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  state_t     state;
  logic [1:0] op_en;
  logic [1:0] op_en_nxt;
  logic       wr_ignored;
  logic       done_ok;
  logic       retire_go;

  // The dp_start register marks the launch cycle; a done in that cycle is stale.
  assign done_ok = (state == S_BUSY) && !dp_start && dp_done;

`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 tmo_hit;

  // Counter holds (busy cycle index - 1), so the hit lands in the TIMEOUT_CYCLES-th busy cycle.
  assign tmo_hit    = (state == S_BUSY) && (tmo_cnt == TMO_LAST);
  assign retire_go  = done_ok || tmo_hit;
  assign dp_timeout = tmo_hit && !done_ok;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], TMO_CNT_W[0]};
  assign retire_go  = done_ok;
`endif

  // Clearing the running group is refused; a software set during RETIRE beats the hardware clear.
  assign wr_ignored = !op_en_wr_data && (state != S_IDLE) && (producer == consumer);

  always_comb begin
    op_en_nxt = op_en;
    if (state == S_RETIRE) begin
      op_en_nxt[consumer] = 1'b0;
    end
    if (op_en_wr_en && !wr_ignored) begin
      op_en_nxt[producer] = op_en_wr_data;
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state     <= S_IDLE;
      consumer  <= 1'b0;
      op_en     <= 2'b00;
      dp_start  <= 1'b0;
      dp_busy   <= 1'b0;
      intr_done <= 2'b00;
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      op_en     <= op_en_nxt;
      dp_start  <= 1'b0;
      intr_done <= 2'b00;
      case (state)
        S_IDLE: begin
          if (op_en[consumer]) begin
            state    <= S_BUSY;
            dp_start <= 1'b1;
            dp_busy  <= 1'b1;
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        S_BUSY: begin
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (retire_go) begin
            state     <= S_RETIRE;
            dp_busy   <= 1'b0;
            intr_done <= consumer ? 2'b10 : 2'b01;
          end
        end
        S_RETIRE: begin
          consumer <= ~consumer;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status_0 = ST_IDLE;
    status_1 = ST_IDLE;
    if (op_en[0]) begin
      status_0 = (consumer == 1'b0) ? ST_RUNNING : ST_PENDING;
    end
    if (op_en[1]) begin
      status_1 = (consumer == 1'b1) ? ST_RUNNING : ST_PENDING;
    end
  end

  assign op_en_0 = op_en[0];
  assign op_en_1 = op_en[1];
  assign cfg_sel = consumer;

endmodule

// File: tb/tb_autosa_cacc_regfile_consumer.sv
// tb/tb_autosa_cacc_regfile_consumer.sv - scoreboard bench for autosa_cacc_regfile_consumer
// Reference model tracks groups, job phase and busy age; monitor compares every cycle.
module tb_autosa_cacc_regfile_consumer;

  localparam int TMO = 10;

  logic       autosa_core_clk = 1'b0;
  logic       autosa_core_rst;
  logic       producer;
  logic       op_en_wr_en;
  logic       op_en_wr_data;
  logic       dp_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       op_en_0;
  logic       op_en_1;
  logic       cfg_sel;
  logic       dp_start;
  logic       dp_busy;
  logic [1:0] intr_done;
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
  logic       dp_timeout;
`endif

  autosa_cacc_regfile_consumer #(
    .TIMEOUT_CYCLES(TMO),
    .TMO_CNT_W     (16)
  ) dut (
    .autosa_core_clk(autosa_core_clk),
    .autosa_core_rst(autosa_core_rst),
    .producer       (producer),
    .op_en_wr_en    (op_en_wr_en),
    .op_en_wr_data  (op_en_wr_data),
    .dp_done        (dp_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .op_en_0        (op_en_0),
    .op_en_1        (op_en_1),
    .cfg_sel        (cfg_sel),
    .dp_start       (dp_start),
    .dp_busy        (dp_busy),
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
    .dp_timeout     (dp_timeout),
`endif
    .intr_done      (intr_done)
  );

  always #5 autosa_core_clk = ~autosa_core_clk;

  typedef struct {
    bit       start;
    bit [1:0] intr;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Model: phase 0 waiting, 1 job running, 2 retiring; age counts busy cycles from 1.
  bit       m_live = 1'b0;
  bit       m_cons;
  bit [1:0] m_en;
  int       m_ph;
  bit       m_first;
  int       m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_status(input bit [1:0] en, input bit cons, input bit g);
    if (!en[g]) return 0;
    return (cons == g) ? 1 : 2;
  endfunction

  always @(posedge autosa_core_clk) begin
    bit [1:0] n_en;
    bit       fin;
    ev_t      ev;
    cyc++;
    if (autosa_core_rst) begin
      m_live  = 1'b1;
      m_cons  = 1'b0;
      m_en    = 2'b00;
      m_ph    = 0;
      m_first = 1'b0;
      m_age   = 0;
      exp_q.delete();
    end else if (m_live) begin
      n_en = m_en;
      if (m_ph == 2) n_en[m_cons] = 1'b0;
      if (op_en_wr_en && !(!op_en_wr_data && m_ph != 0 && producer == m_cons))
        n_en[producer] = op_en_wr_data;
      if (m_ph == 0) begin
        if (m_en[m_cons]) begin
          m_ph = 1; m_first = 1'b1; m_age = 1;
          ev.start = 1'b1; ev.intr = 2'b00; ev.cyc = cyc;
          exp_q.push_back(ev);
        end
      end else if (m_ph == 1) begin
        fin = dp_done && !m_first;
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
        if (m_age == TMO) fin = 1'b1;
`endif
        m_first = 1'b0;
        if (fin) begin
          m_ph = 2;
          ev.start = 1'b0; ev.intr = m_cons ? 2'b10 : 2'b01; ev.cyc = cyc;
          exp_q.push_back(ev);
        end else begin
          m_age++;
        end
      end else begin
        m_ph = 0;
        m_cons = !m_cons;
      end
      m_en = n_en;
    end
  end

  always @(negedge autosa_core_clk) begin
    ev_t e;
    if (m_live) begin
      chk("consumer", 32'(consumer), 32'(m_cons));
      chk("cfg_sel", 32'(cfg_sel), 32'(m_cons));
      chk("op_en_0", 32'(op_en_0), 32'(m_en[0]));
      chk("op_en_1", 32'(op_en_1), 32'(m_en[1]));
      chk("status_0", 32'(status_0), 32'(exp_status(m_en, m_cons, 1'b0)));
      chk("status_1", 32'(status_1), 32'(exp_status(m_en, m_cons, 1'b1)));
      chk("dp_busy", 32'(dp_busy), 32'(m_ph == 1));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
      end else begin
        e.start = 1'b0; e.intr = 2'b00; e.cyc = cyc;
      end
      chk("dp_start", 32'(dp_start), 32'(e.start));
      chk("intr_done", 32'(intr_done), 32'(e.intr));
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
      chk("dp_timeout", 32'(dp_timeout),
          32'(m_ph == 1 && m_age == TMO && !(dp_done && !m_first)));
`endif
    end
  end

  task automatic step(input bit p, input bit we, input bit wd, input bit dn, input bit rs);
    producer      = p;
    op_en_wr_en   = we;
    op_en_wr_data = wd;
    dp_done       = dn;
    autosa_core_rst = rs;
    @(posedge autosa_core_clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // single job on group 0, done well after launch
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(13);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // back to back groups, clear of running group, done coincident with start, done in idle
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(m_cons, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // software re-arm of the consumer group during RETIRE
    step(m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    step(!m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
`ifdef AUTOSA_CACC_CONSUMER_TIMEOUT_EN
    step(m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(16);
`endif
    // reset in the middle of a job
    step(m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    step(!m_cons, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle(4);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
